// File: rtl/telecom_rx_pkg.sv
// rtl/telecom_rx_pkg.sv - shared defaults, types and helpers for the rx bit recovery front-end
package telecom_rx_pkg;

    localparam int OVS_DEFAULT         = 8;
    localparam int LOCK_EDGES_DEFAULT  = 4;
    localparam int LOS_CYCLES_DEFAULT  = 64;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef logic [15:0] edge_cnt_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/rx_bit_recovery_if.sv
// rtl/rx_bit_recovery_if.sv - line pair in, recovered bit stream and status out
interface rx_bit_recovery_if;
    import telecom_rx_pkg::*;

    logic      rxp_n;
    logic      rxn_n;
    logic      bit_out;
    logic      bit_valid;
    logic      locked;
    logic      sig_lost;
    edge_cnt_t edge_cnt;

    // slave: the recovery block; master: whatever drives the line and consumes bits
    modport slave (
        input  rxp_n,
        input  rxn_n,
        output bit_out,
        output bit_valid,
        output locked,
        output sig_lost,
        output edge_cnt
    );

    modport master (
        output rxp_n,
        output rxn_n,
        input  bit_out,
        input  bit_valid,
        input  locked,
        input  sig_lost,
        input  edge_cnt
    );

endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - STAGES-deep single-bit synchroniser, async active-high reset
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/rx_bit_recovery.sv
// rtl/rx_bit_recovery.sv - oversampled bit recovery with edge realignment, lock and LOS
module rx_bit_recovery
    import telecom_rx_pkg::*;
#(
    parameter int OVERSAMPLE  = OVS_DEFAULT,
    parameter int LOCK_EDGES  = LOCK_EDGES_DEFAULT,
    parameter int LOS_CYCLES  = LOS_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input logic              CLK,
    input logic              RST,
    rx_bit_recovery_if.slave rx
);

    localparam int PH_W   = $clog2(OVERSAMPLE);
    localparam int GOOD_W = $clog2(LOCK_EDGES + 1);
    localparam int INV_W  = $clog2(LOS_CYCLES + 1);

    typedef logic [PH_W-1:0]   ph_t;
    typedef logic [GOOD_W-1:0] good_t;
    typedef logic [INV_W-1:0]  inv_t;

    localparam ph_t   PH_LAST  = ph_t'(OVERSAMPLE - 1);
    localparam ph_t   PH_HALF  = ph_t'(OVERSAMPLE / 2);
    localparam good_t GOOD_MAX = good_t'(LOCK_EDGES);
    localparam inv_t  INV_MAX  = inv_t'(LOS_CYCLES);

    logic p_s;
    logic n_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_p (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (rx.rxp_n),
        .q_o   (p_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_n (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (rx.rxn_n),
        .q_o   (n_s)
    );

    logic      dec_q,    dec_d;
    logic      lvl_q;
    ph_t       ph_q,     ph_d;
    logic [2:0] hist_q,  hist_d;
    good_t     good_q,   good_d;
    inv_t      inv_q,    inv_d;
    logic      locked_q, locked_d;
    logic      lost_q,   lost_d;
    logic      bv_q,     bv_d;
    logic      bo_q,     bo_d;
    edge_cnt_t ecnt_q,   ecnt_d;

    logic pair_valid;
    logic edge_det;
    logic sample;
    logic good_edge;

    // Legs are inverted: p_s=0/n_s=1 is a line 1; equal legs carry no information
    assign pair_valid = p_s ^ n_s;
    assign dec_d      = pair_valid ? ~p_s : dec_q;
    assign edge_det   = dec_q ^ lvl_q;
    assign sample     = (ph_q == PH_HALF) && !edge_det;
    assign good_edge  = (ph_q == PH_LAST) || (ph_q == '0) || (ph_q == ph_t'(1));
    assign hist_d     = {hist_q[1:0], dec_q};

    always_comb begin
        ph_d = ph_q;
        if (edge_det) begin
            ph_d = ph_t'(1);
        end else if (ph_q == PH_LAST) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + ph_t'(1);
        end
    end

    always_comb begin
        inv_d = inv_q;
        if (pair_valid) begin
            inv_d = '0;
        end else if (inv_q != INV_MAX) begin
            inv_d = inv_q + inv_t'(1);
        end
    end

    assign lost_d = (inv_d == INV_MAX);

    // LOS wins over edge bookkeeping so a coincident bad edge and LOS both leave lock at 0
    always_comb begin
        good_d = good_q;
        if (lost_d) begin
            good_d = '0;
        end else if (edge_det) begin
            if (!good_edge) begin
                good_d = '0;
            end else if (good_q != GOOD_MAX) begin
                good_d = good_q + good_t'(1);
            end
        end
    end

    assign locked_d = (good_d == GOOD_MAX) && !lost_d;
    assign bv_d     = sample && !lost_q;
    assign bo_d     = sample ? maj3(hist_q) : bo_q;
    assign ecnt_d   = ecnt_q + edge_cnt_t'(edge_det);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dec_q    <= 1'b0;
            lvl_q    <= 1'b0;
            ph_q     <= '0;
            hist_q   <= '0;
            good_q   <= '0;
            inv_q    <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            bv_q     <= 1'b0;
            bo_q     <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            dec_q    <= dec_d;
            lvl_q    <= dec_q;
            ph_q     <= ph_d;
            hist_q   <= hist_d;
            good_q   <= good_d;
            inv_q    <= inv_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            bv_q     <= bv_d;
            bo_q     <= bo_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign rx.bit_out   = bo_q;
    assign rx.bit_valid = bv_q;
    assign rx.locked    = locked_q;
    assign rx.sig_lost  = lost_q;
    assign rx.edge_cnt  = ecnt_q;

endmodule

// File: tb/tb_rx_bit_recovery.sv
// tb/tb_rx_bit_recovery.sv - self-checking bench for rx_bit_recovery
module tb_rx_bit_recovery;
    import telecom_rx_pkg::*;

    localparam int OVS  = 8;
    localparam int LOCK = 4;
    localparam int LOS  = 64;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rx_bit_recovery_if rx_bus ();

    rx_bit_recovery #(
        .OVERSAMPLE  (OVS),
        .LOCK_EDGES  (LOCK),
        .LOS_CYCLES  (LOS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .rx  (rx_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int vcount   = 0;
    bit lock_dropped = 1'b0;

    // Reference: line view after the synchroniser delay, phase = cycles since the last edge mod OVS
    bit   m_sp [SYNC];
    bit   m_sn [SYNC];
    bit   m_dec, m_lvl, m_lost, m_locked, m_bv, m_bo;
    int   m_since, m_inv, m_gc;
    int   m_hist[$];
    logic [15:0] m_ecnt;

    typedef struct {
        int kind;
        int val;
        int len;
        int exp_locked;
        int exp_lost;
        int exp_ecnt;
        int exp_valid;
    } seg_t;

    seg_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) begin
            m_sp[i] = 1'b0;
            m_sn[i] = 1'b0;
        end
        m_dec = 0; m_lvl = 0; m_lost = 0; m_locked = 0; m_bv = 0; m_bo = 0;
        m_since = 0; m_inv = 0; m_gc = 0; m_ecnt = '0;
        m_hist = {0, 0, 0};
    endtask

    task automatic model_step(input bit p, input bit n);
        bit ps, ns, valid, edge_now, sample, good, lost_n;
        int ph, inv_n, gc_n;
        ps       = m_sp[SYNC-1];
        ns       = m_sn[SYNC-1];
        valid    = (ps != ns);
        edge_now = (m_dec != m_lvl);
        ph       = m_since % OVS;
        sample   = (ph == OVS/2) && !edge_now;
        good     = (ph == OVS-1) || (ph <= 1);
        inv_n    = valid ? 0 : ((m_inv < LOS) ? m_inv + 1 : LOS);
        lost_n   = (inv_n == LOS);
        if (lost_n) gc_n = 0;
        else if (edge_now) gc_n = good ? ((m_gc < LOCK) ? m_gc + 1 : LOCK) : 0;
        else gc_n = m_gc;
        m_bv = sample && !m_lost;
        if (sample) m_bo = ((m_hist[0] + m_hist[1] + m_hist[2]) >= 2);
        if (edge_now) m_ecnt = m_ecnt + 16'd1;
        m_since = edge_now ? 1 : m_since + 1;
        m_hist.push_front(int'(m_dec));
        void'(m_hist.pop_back());
        m_lvl = m_dec;
        if (valid) m_dec = !ps;
        m_inv = inv_n; m_lost = lost_n; m_gc = gc_n;
        m_locked = (gc_n == LOCK) && !lost_n;
        for (int i = SYNC-1; i > 0; i--) begin
            m_sp[i] = m_sp[i-1];
            m_sn[i] = m_sn[i-1];
        end
        m_sp[0] = p;
        m_sn[0] = n;
    endtask

    task automatic cycle(input bit p, input bit n);
        rx_bus.rxp_n = p;
        rx_bus.rxn_n = n;
        @(posedge clk);
        model_step(p, n);
        @(negedge clk);
        if (rx_bus.bit_valid === 1'b1) vcount++;
        if (rx_bus.locked !== 1'b1) lock_dropped = 1'b1;
        check("bit_valid", 32'(rx_bus.bit_valid), 32'(m_bv));
        check("locked",    32'(rx_bus.locked),    32'(m_locked));
        check("sig_lost",  32'(rx_bus.sig_lost),  32'(m_lost));
        check("edge_cnt",  32'(rx_bus.edge_cnt),  32'(m_ecnt));
        if (m_bv) check("bit_out", 32'(rx_bus.bit_out), 32'(m_bo));
    endtask

    task automatic drive_line(input bit v, input int ncyc);
        repeat (ncyc) cycle(!v, v);
    endtask

    task automatic add_seg(input int k, input int v, input int len, input int lk,
                           input int ls, input int ec, input int vl);
        seg_t s;
        s.kind = k; s.val = v; s.len = len;
        s.exp_locked = lk; s.exp_lost = ls; s.exp_ecnt = ec; s.exp_valid = vl;
        tbl.push_back(s);
    endtask

    task automatic run_seg(input seg_t s, input string tag, input int idx);
        vcount = 0;
        repeat (s.len) begin
            if (s.kind == 1) cycle(1'b1, 1'b1);
            else cycle(!s.val[0], s.val[0]);
        end
        if (s.exp_locked >= 0)
            check($sformatf("%s%0d_locked", tag, idx), 32'(rx_bus.locked), 32'(s.exp_locked));
        if (s.exp_lost >= 0)
            check($sformatf("%s%0d_sig_lost", tag, idx), 32'(rx_bus.sig_lost), 32'(s.exp_lost));
        if (s.exp_ecnt >= 0)
            check($sformatf("%s%0d_edge_cnt", tag, idx), 32'(rx_bus.edge_cnt), 32'(s.exp_ecnt));
        if (s.exp_valid >= 0)
            check($sformatf("%s%0d_valid_count", tag, idx), 32'(vcount), 32'(s.exp_valid));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bit_out"},   32'(rx_bus.bit_out),   32'd0);
        check({tag, "_bit_valid"}, 32'(rx_bus.bit_valid), 32'd0);
        check({tag, "_locked"},    32'(rx_bus.locked),    32'd0);
        check({tag, "_sig_lost"},  32'(rx_bus.sig_lost),  32'd0);
        check({tag, "_edge_cnt"},  32'(rx_bus.edge_cnt),  32'd0);
    endtask

    task automatic period_run(input int per, input int nbits, input bit first, input string tag);
        bit v;
        v = first;
        vcount = 0;
        lock_dropped = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            drive_line(v, per);
            v = !v;
        end
        check({tag, "_lock_held"}, 32'(lock_dropped), 32'd0);
        check({tag, "_bits_in_range"}, 32'((vcount >= nbits - 1) && (vcount <= nbits + 1)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // kind(0 line/1 invalid), value, cycles, locked, sig_lost, edge_cnt, strobes (-1 = don't care)
        add_seg(0, 0,  16,  0, 0,  0, -1);
        add_seg(0, 1,   8,  0, 0,  1, -1);
        add_seg(0, 0,   8,  0, 0,  2, -1);
        add_seg(0, 1,   8,  0, 0,  3, -1);
        add_seg(0, 0,   8, -1, 0,  4, -1);
        add_seg(0, 1,   8,  1, 0,  5, -1);
        add_seg(0, 0,   8,  1, 0,  6, -1);
        add_seg(0, 0, 320,  1, 0,  6, 40);
        add_seg(0, 1,   3, -1, 0, -1, -1);
        add_seg(0, 0,   1, -1, 0, -1, -1);
        add_seg(0, 1,   4,  0, 0,  9, -1);
        add_seg(0, 0,   8,  0, 0, 10, -1);
        add_seg(0, 1,   8,  0, 0, 11, -1);
        add_seg(0, 0,   8,  0, 0, 12, -1);
        add_seg(0, 1,   8,  0, 0, 13, -1);
        add_seg(0, 0,   8,  1, 0, 14, -1);
        add_seg(1, 0,  65,  1, 0, 14, -1);
        add_seg(1, 0,   1,  0, 1, 14, -1);
        add_seg(1, 0,   4,  0, 1, 14,  0);
        add_seg(0, 0,   2,  0, 1, 14,  0);
        add_seg(0, 0,   1,  0, 0, 14,  0);
        add_seg(0, 1,   8,  0, 0, 15, -1);
        add_seg(0, 0,   8,  0, 0, 16, -1);
        add_seg(0, 1,   8,  0, 0, 17, -1);
        add_seg(0, 0,   8, -1, 0, 18, -1);
        add_seg(0, 1,   8,  1, 0, 19, -1);
        add_seg(0, 0,   8,  1, 0, 20, -1);

        rx_bus.rxp_n = 1'b1;
        rx_bus.rxn_n = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_seg(tbl[i], "seg", i);

        // asynchronous reset in the middle of a bit while locked
        drive_line(1'b1, 3);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b0;
        for (int i = 0; i <= 6; i++) run_seg(tbl[i], "relock", i);

        period_run(7, 100, 1'b1, "period7");
        period_run(9, 100, 1'b1, "period9");

        // random bit periods, glitches and invalid bursts against the reference
        for (int b = 0; b < 300; b++) begin
            bit v;
            int per;
            v   = 1'($urandom_range(0, 1));
            per = int'($urandom_range(7, 9));
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(1, 80)) cycle(1'b1, 1'b1);
            end
            if ($urandom_range(0, 15) == 0) begin
                drive_line(v, 3);
                drive_line(!v, 1);
                drive_line(v, per - 4);
            end else begin
                drive_line(v, per);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_bit_recovery.md
Name: rx_bit_recovery

Overview:
- Receive front-end for the inverted-polarity differential line pair (rxp_n/rxn_n) driven by the external comparator.
- Synchronises both legs into CLK and decodes the line level.
- Recovers bit timing by oversampling, with phase realignment on each edge.
- Emits one recovered bit per bit period, plus lock and loss-of-signal status, to the downstream deframer in the transceiver core.

Parameters:
- OVERSAMPLE, 8, CLK cycles per bit; even, ≥4
- LOCK_EDGES, 4, consecutive well-aligned edges required to assert locked
- LOS_CYCLES, 64, consecutive invalid-pair cycles before sig_lost asserts
- SYNC_STAGES, 2, flip-flops in each input synchroniser; ≥2

Ports:
- CLK  in  1  main core clock
- RST  in  1  asynchronous reset, active-high
- rxp_n  in  1  inverted positive leg, asynchronous
- rxn_n  in  1  inverted negative leg, asynchronous
- bit_out  out  1  recovered bit, valid when bit_valid=1
- bit_valid  out  1  one-cycle strobe, one per bit period
- locked  out  1  bit timing aligned to line edges
- sig_lost  out  1  line pair invalid for ≥LOS_CYCLES cycles
- edge_cnt  out  16  line transitions since reset; wraps

Behaviour:
- Reset (async, RST=1): all sync flops, level register, history, counters and outputs clear to 0. Phase counter clears to 0. Operation resumes on the first CLK edge after RST falls. Reset mid-bit discards any partial bit.
- Sync: each leg passes through SYNC_STAGES flops → p_s, n_s.
- Decode, registered as d:
  - p_s != n_s: d <= ~p_s, so p_s=0/n_s=1 means line 1.
  - p_s == n_s: invalid; d holds its previous value.
- Level register d_q <= d, giving a pin-to-d_q latency of SYNC_STAGES+2 cycles.
- Edge: d != d_q. On an edge cycle, edge_cnt increments mod 2^16.
- Phase counter ph, range 0..OVERSAMPLE-1:
  - Edge cycle: ph <= 1. The edge cycle itself is phase 0.
  - Otherwise: ph <= ph+1, wrapping OVERSAMPLE-1 → 0. It free-runs through long constant runs, so bits keep being produced.
- History: hist[2:0] shifts in d every cycle.
- Sample: when ph == OVERSAMPLE/2 and no edge this cycle, next cycle bit_out <= majority(hist) and bit_valid=1 for exactly one cycle. An edge cycle that coincides with ph == OVERSAMPLE/2 does not sample, because ph is reset.
- Alignment check, on each edge, using the pre-edge ph:
  - ph ∈ {OVERSAMPLE-1, 0, 1} is a good edge: good_cnt saturates at LOCK_EDGES; locked=1 once good_cnt==LOCK_EDGES.
  - Any other ph is a bad edge: good_cnt <= 0 and locked <= 0 in the same cycle.
- LOS:
  - inv_cnt increments on each invalid cycle, saturating at LOS_CYCLES, and clears to 0 on any valid cycle.
  - sig_lost = (inv_cnt == LOS_CYCLES), registered.
  - While sig_lost=1: locked forced 0, good_cnt held at 0, bit_valid suppressed.
  - Recovery: the first valid cycle clears sig_lost on the next edge of CLK. Relock then needs LOCK_EDGES good edges.
- Simultaneous bad edge and LOS assertion: both take effect, locked=0.
- bit_valid is never asserted in two consecutive cycles.

Decomposition:
- Package telecom_rx_pkg holds:
  - Defaults: OVS_DEFAULT=8, LOCK_EDGES_DEFAULT=4, LOS_CYCLES_DEFAULT=64.
  - Function maj3.
  - Typedef edge_cnt_t (16-bit).
- One sub-module, sync_ff: a parameterised SYNC_STAGES-deep single-bit synchroniser with async active-high reset, instantiated once per leg.

Test Plan:
- Alternating 1,0,1,0 at exactly 8 cycles/bit (rxp_n = ~bit, rxn_n = bit) → bit_valid every 8 cycles, bits 1,0,1,0; locked=1 after the 4th edge; edge_cnt tracks transitions.
- After lock, hold line at 0 for 40 bit periods → 40 bit_valid strobes of 0, spaced 8 cycles apart; locked stays 1.
- After lock, inject a single-cycle glitch mid-bit → glitch bit still decoded correctly by majority; then an edge at ph=4 → locked drops to 0 that cycle; 4 further aligned edges → locked=1.
- Drive rxp_n=rxn_n=1 for 64 cycles → sig_lost=1 after the 64th; no bit_valid; restore a valid pair → sig_lost=0 one cycle later; relock after 4 good edges.
- Assert RST for 1 cycle mid-bit while locked → all outputs 0 asynchronously; edge_cnt=0; normal recovery and relock after release.
- Bits at 7- and 9-cycle periods → every edge stays within ±1 of the expected boundary; locked holds; no bit dropped or duplicated over 100 bits.
